// File: rtl/bram_port_scheduler.sv
// bram_port_scheduler: grants one shared BRAM port to the requester with the
// smallest {~req, key} entry (lowest index on ties), holds it for a burst of
// acknowledged beats, then inserts one turnaround cycle before re-arbitrating.
// Optional build macro: BRAM_SCHED_AGING_EN adds per-unit age counters that
// lower the effective key of requesters that keep losing.
module bram_port_scheduler #(
    parameter int unsigned NUM_UNITS = 16,
    parameter int unsigned WIDTH_KEY = 4,
    parameter int unsigned WIDTH_LEN = 8,
    localparam int unsigned ID_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_UNITS-1:0]           I_Req,
    input  logic [NUM_UNITS*WIDTH_KEY-1:0] I_Key,
    input  logic [NUM_UNITS*WIDTH_LEN-1:0] I_Len,
    input  logic                           I_Ack,
    output logic [NUM_UNITS-1:0]           O_Grant,
    output logic [ID_W-1:0]                O_Grant_ID,
    output logic                           O_Busy
);

    localparam int unsigned EW = WIDTH_KEY + 1;
    localparam int unsigned NL = 1 << ID_W;
    localparam int unsigned NN = 2 * NL - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [NUM_UNITS-1:0]   grant_d;
    logic [ID_W-1:0]        id_d;
    logic                   busy_d;
    logic [WIDTH_LEN-1:0]   rem_q;
    logic [WIDTH_LEN-1:0]   rem_d;
    logic [ID_W-1:0]        owner_q;
    logic [ID_W-1:0]        owner_d;
    logic                   armed_q;

    logic [WIDTH_KEY-1:0]   eff_key [NUM_UNITS];
    logic [EW-1:0]          node_val [NN];
    logic [ID_W-1:0]        node_idx [NN];
    logic [ID_W-1:0]        win;
    logic [WIDTH_LEN-1:0]   win_len;

`ifdef BRAM_SCHED_AGING_EN
    logic [WIDTH_KEY-1:0]   age_q [NUM_UNITS];

    // Effective key: requested key reduced by age, floored at zero
    always_comb begin
        for (int i = 0; i < int'(NUM_UNITS); i++) begin
            eff_key[i] = (I_Key[i*WIDTH_KEY +: WIDTH_KEY] > age_q[i])
                       ? I_Key[i*WIDTH_KEY +: WIDTH_KEY] - age_q[i]
                       : '0;
        end
    end

    // Age update in the turnaround cycle: winner and idle units clear, losers count up
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_UNITS); i++) begin
                age_q[i] <= '0;
            end
        end else if (state_q == REL) begin
            for (int i = 0; i < int'(NUM_UNITS); i++) begin
                if (ID_W'(i) == owner_q || !I_Req[i]) begin
                    age_q[i] <= '0;
                end else if (age_q[i] != '1) begin
                    age_q[i] <= age_q[i] + WIDTH_KEY'(1);
                end
            end
        end
    end
`else
    // Effective key is the raw key
    always_comb begin
        for (int i = 0; i < int'(NUM_UNITS); i++) begin
            eff_key[i] = I_Key[i*WIDTH_KEY +: WIDTH_KEY];
        end
    end
`endif

    // Minimum tournament tree; left child wins ties so the lower index is preferred
    always_comb begin
        for (int n = 0; n < int'(NN); n++) begin
            node_val[n] = '1;
            node_idx[n] = '0;
        end
        for (int i = 0; i < int'(NUM_UNITS); i++) begin
            node_val[int'(NL) - 1 + i] = {~I_Req[i], eff_key[i]};
            node_idx[int'(NL) - 1 + i] = ID_W'(i);
        end
        for (int i = int'(NUM_UNITS); i < int'(NL); i++) begin
            node_idx[int'(NL) - 1 + i] = ID_W'(i);
        end
        for (int n = int'(NL) - 2; n >= 0; n--) begin
            if (node_val[2*n+1] <= node_val[2*n+2]) begin
                node_val[n] = node_val[2*n+1];
                node_idx[n] = node_idx[2*n+1];
            end else begin
                node_val[n] = node_val[2*n+2];
                node_idx[n] = node_idx[2*n+2];
            end
        end
        win     = node_idx[0];
        win_len = I_Len[win*WIDTH_LEN +: WIDTH_LEN];
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        grant_d = O_Grant;
        id_d    = O_Grant_ID;
        busy_d  = O_Busy;
        rem_d   = rem_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                id_d    = '0;
                busy_d  = 1'b0;
                rem_d   = '0;
                if (armed_q && (|I_Req)) begin
                    state_d = BUSY;
                    grant_d = NUM_UNITS'(1) << win;
                    id_d    = win;
                    busy_d  = 1'b1;
                    rem_d   = (win_len == '0) ? WIDTH_LEN'(1) : win_len;
                    owner_d = win;
                end
            end
            BUSY: begin
                if (I_Ack && (rem_q > WIDTH_LEN'(1))) begin
                    rem_d = rem_q - WIDTH_LEN'(1);
                end
                // Abort on request drop, or release after the last acked beat
                if (!I_Req[owner_q] || (I_Ack && (rem_q == WIDTH_LEN'(1)))) begin
                    state_d = REL;
                    grant_d = '0;
                    id_d    = '0;
                    busy_d  = 1'b0;
                    rem_d   = '0;
                end
            end
            REL: begin
                state_d = IDLE;
                grant_d = '0;
                id_d    = '0;
                busy_d  = 1'b0;
                rem_d   = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                id_d    = '0;
                busy_d  = 1'b0;
                rem_d   = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            O_Grant    <= '0;
            O_Grant_ID <= '0;
            O_Busy     <= 1'b0;
            rem_q      <= '0;
            owner_q    <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            O_Grant    <= grant_d;
            O_Grant_ID <= id_d;
            O_Busy     <= busy_d;
            rem_q      <= rem_d;
            owner_q    <= owner_d;
            armed_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bram_port_scheduler.sv
// Directed bench for bram_port_scheduler (16 units, 4-bit keys, 8-bit lengths).
module tb_bram_port_scheduler;

    logic        clock;
    logic        reset;
    logic [15:0] req;
    logic [63:0] key;
    logic [127:0] len;
    logic        ack;
    logic [15:0] grant;
    logic [3:0]  gid;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int first_win = 0;

`ifdef BRAM_SCHED_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    bram_port_scheduler #(
        .NUM_UNITS(16),
        .WIDTH_KEY(4),
        .WIDTH_LEN(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .I_Req      (req),
        .I_Key      (key),
        .I_Len      (len),
        .I_Ack      (ack),
        .O_Grant    (grant),
        .O_Grant_ID (gid),
        .O_Busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] g, input logic [3:0] id, input logic b);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".id"},    32'(gid),   32'(id));
        chk({tag, ".busy"},  32'(busy),  32'(b));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_key(input int u, input int k);
        key[u*4 +: 4] = 4'(k);
    endtask

    task automatic set_len(input int u, input int l);
        len[u*8 +: 8] = 8'(l);
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        key   = '0;
        len   = '0;
        ack   = 1'b0;
        #2;
        chk_out("reset", 16'h0000, 4'd0, 1'b0);
        #10 reset = 1'b0;

        // Idle with no requests
        for (int c = 0; c < 10; c++) begin
            tick();
            chk_out("idle", 16'h0000, 4'd0, 1'b0);
        end

        // Key priority: unit 7 (key 2) beats unit 3 (key 5)
        set_key(3, 5); set_key(7, 2); set_len(7, 3); set_len(3, 2);
        req = 16'h0088; ack = 1'b1;
        tick(); chk_out("prio.g7a", 16'h0080, 4'd7, 1'b1);
        tick(); chk_out("prio.g7b", 16'h0080, 4'd7, 1'b1);
        tick(); chk_out("prio.g7c", 16'h0080, 4'd7, 1'b1);
        tick(); chk_out("prio.rel", 16'h0000, 4'd0, 1'b0);
        req = 16'h0008;
        tick(); chk_out("prio.idle", 16'h0000, 4'd0, 1'b0);
        tick(); chk_out("prio.g3a", 16'h0008, 4'd3, 1'b1);
        tick(); chk_out("prio.g3b", 16'h0008, 4'd3, 1'b1);
        tick(); chk_out("prio.rel2", 16'h0000, 4'd0, 1'b0);
        req = 16'h0000;
        tick(); chk_out("prio.idle2", 16'h0000, 4'd0, 1'b0);

        // Tie on key 4: lower index wins; zero length is one beat
        set_key(2, 4); set_key(9, 4); set_len(2, 0); set_len(9, 1);
        req = 16'h0204;
        tick(); chk_out("tie.g2", 16'h0004, 4'd2, 1'b1);
        tick(); chk_out("tie.rel", 16'h0000, 4'd0, 1'b0);
        req = 16'h0200;
        tick(); chk_out("tie.idle", 16'h0000, 4'd0, 1'b0);
        tick(); chk_out("tie.g9", 16'h0200, 4'd9, 1'b1);
        tick(); chk_out("tie.rel2", 16'h0000, 4'd0, 1'b0);
        req = 16'h0000;
        tick(); chk_out("tie.idle2", 16'h0000, 4'd0, 1'b0);

        // Ack stalls then abort by dropping the request
        set_key(5, 1); set_len(5, 4);
        req = 16'h0020; ack = 1'b1;
        tick(); chk_out("stall.g", 16'h0020, 4'd5, 1'b1);
        ack = 1'b1; tick(); chk_out("stall.a1", 16'h0020, 4'd5, 1'b1);
        ack = 1'b0; tick(); chk_out("stall.s1", 16'h0020, 4'd5, 1'b1);
        ack = 1'b0; tick(); chk_out("stall.s2", 16'h0020, 4'd5, 1'b1);
        ack = 1'b1; tick(); chk_out("stall.a2", 16'h0020, 4'd5, 1'b1);
        req = 16'h0000; ack = 1'b0;
        tick(); chk_out("abort.rel", 16'h0000, 4'd0, 1'b0);
        req = 16'h0020;
        tick(); chk_out("abort.idle", 16'h0000, 4'd0, 1'b0);
        tick(); chk_out("abort.regrant", 16'h0020, 4'd5, 1'b1);

        // Asynchronous reset with two beats remaining
        ack = 1'b1;
        tick(); chk_out("rst.b1", 16'h0020, 4'd5, 1'b1);
        tick(); chk_out("rst.b2", 16'h0020, 4'd5, 1'b1);
        #3 reset = 1'b1;
        #1 chk_out("rst.async", 16'h0000, 4'd0, 1'b0);
        set_len(5, 3);
        @(posedge clock);
        #2 reset = 1'b0;
        tick(); chk_out("rst.first_edge", 16'h0000, 4'd0, 1'b0);
        tick(); chk_out("rst.g1", 16'h0020, 4'd5, 1'b1);
        tick(); chk_out("rst.g2", 16'h0020, 4'd5, 1'b1);
        tick(); chk_out("rst.g3", 16'h0020, 4'd5, 1'b1);
        tick(); chk_out("rst.rel", 16'h0000, 4'd0, 1'b0);
        req = 16'h0000;
        tick(); chk_out("rst.idle", 16'h0000, 4'd0, 1'b0);

        // Starvation: unit 0 key 15 vs round-robin key-0 units
        for (int u = 0; u < 16; u++) begin
            set_key(u, (u == 0) ? 15 : 0);
            set_len(u, 1);
        end
        ack = 1'b1;
        for (int a = 0; a < 20; a++) begin
            int k;
            int exp_w;
            k = 1 + (a % 15);
            exp_w = (AGING && a == 15) ? 0 : k;
            req = 16'h0001 | (16'h0001 << k);
            tick();
            chk("age.winner", 32'(gid), 32'(exp_w));
            chk("age.grant", 32'(grant), 32'(16'h0001 << exp_w));
            if (gid == 4'd0 && busy && first_win == 0) first_win = a + 1;
            tick();
            tick();
        end
        chk("age.first_win", 32'(first_win), AGING ? 32'd16 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_port_scheduler.md
Name: bram_port_scheduler

Overview:
- Arbitrates one shared BRAM port among NUM_UNITS requesters by running a minimum-key tournament over the pending requests.
- Holds the grant for a requested burst of beats, then releases the port and re-arbitrates.
- Sits in front of the BRAM interface; the per-unit grant vector drives the port mux select.
- Optional aging prevents starvation of requesters that hold large keys.

Parameters:
- NUM_UNITS, 16, number of requesters (1..64)
- WIDTH_KEY, 4, priority key width; a smaller key means a higher priority
- WIDTH_LEN, 8, burst length field width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- I_Req  in  NUM_UNITS  per-unit request level
- I_Key  in  NUM_UNITS x WIDTH_KEY  per-unit priority key; sampled at arbitration
- I_Len  in  NUM_UNITS x WIDTH_LEN  per-unit burst length in beats; 0 is treated as 1
- I_Ack  in  1  BRAM accepted one beat of the current burst
- O_Grant  out  NUM_UNITS  one-hot grant, registered
- O_Grant_ID  out  $clog2(NUM_UNITS) (min 1)  index of the granted unit
- O_Busy  out  1  port owned (state BUSY)

Behaviour:
- Reset state: state=IDLE; O_Grant=0; O_Grant_ID=0; O_Busy=0; remaining count=0; all ages=0.
- Entry build: each unit forms the entry {~I_Req[i], EffKey[i]}.
  - A non-requesting unit therefore always loses.
  - A smaller value wins.
  - On equal values, the lowest index wins.
- Winner selection is combinational (min tree) and registered at the state transition.
- FSM states: IDLE, BUSY, REL.
- IDLE:
  - If any I_Req is high, latch the winner: O_Grant=onehot(w), O_Grant_ID=w, remaining=max(I_Len[w],1), O_Busy=1; go to BUSY.
  - The grant is visible 1 cycle after the request is seen.
  - If no request is pending, stay in IDLE with all outputs 0.
- BUSY:
  - Each cycle with I_Ack=1 decrements remaining.
  - I_Ack while remaining==1 leads to REL.
  - If I_Req[w] drops while in BUSY (abort), go to REL the next cycle, regardless of I_Ack that cycle. Any beat acked in that cycle still counts.
  - I_Ack while in IDLE or REL is ignored.
  - Changes to I_Key or I_Len of other units have no effect while in BUSY.
- REL:
  - One cycle with O_Grant=0, O_Busy=0 (bus turnaround).
  - Ages are updated in this cycle (see Optional Feature).
  - Always goes to IDLE; the minimum gap between two grants is 2 cycles.
- The width of remaining is WIDTH_LEN; it never wraps below 1 while in BUSY.
- Reset asserted mid-burst returns to the reset state immediately (asynchronous). No grant is presented on the first edge after deassertion.
- O_Grant is never more than one-hot. O_Grant=0 whenever the state is not BUSY.

Optional Feature:
- Macro: BRAM_SCHED_AGING_EN.
- Defined:
  - Each unit has a WIDTH_KEY-bit age counter.
  - In REL: the winner's age is cleared; a unit requesting but not granted increments its age, saturating at 2^WIDTH_KEY-1; a non-requesting unit's age is cleared.
  - EffKey = I_Key - age, saturating at 0.
- Undefined:
  - No age registers exist; EffKey = I_Key (strict key priority, lowest index on ties).

Test Plan:
- Reset then idle:
  - Stimulus: all I_Req=0 for 10 cycles.
  - Required: O_Grant=0, O_Busy=0, O_Grant_ID=0 throughout.
- Key priority:
  - Stimulus: I_Req[3]=I_Req[7]=1, Key3=5, Key7=2, Len7=3, I_Ack held at 1.
  - Required: O_Grant=1<<7 for exactly 3 cycles starting 1 cycle after the request; then REL; then unit 3 is granted.
- Tie and zero length:
  - Stimulus: units 2 and 9 both request with Key=4, Len2=0.
  - Required: unit 2 granted for 1 acked beat, then unit 9 granted.
- Ack stalls and abort:
  - Stimulus: Len=4, I_Ack pattern 1,0,0,1, then I_Req[w] dropped.
  - Required: O_Grant stays set through the stall; drops the cycle after the abort; REL lasts 1 cycle.
- Async reset mid-burst:
  - Stimulus: assert reset with 2 beats remaining.
  - Required: O_Grant/O_Busy go to 0 immediately; IDLE after deassertion; counts are fresh.
- Aging (BRAM_SCHED_AGING_EN defined):
  - Stimulus: unit 0 Key=15 requesting continuously; units 1..15 Key=0 requesting in round-robin.
  - Required: unit 0 is granted within 16 arbitrations.
  - Same stimulus without the macro: unit 0 is never granted.
